lap_timer_core: RTL and testbench

//  Parametrised successor to the single-mode stopwatch: one counter core that runs count-up (stopwatch) or

---
 rtl/lap_timer_core.sv | 241 ++++++++++++++++++++++++
 tb/tb_lap_timer_core.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lap_timer_core.sv
// Stopwatch / countdown core with a lap-snapshot FIFO and a one-cycle done pulse.
// Time fields are plain binary and feed the display controller unchanged.
module lap_timer_core #(
    parameter int TICK_DIV  = 1_000_000,
    parameter int HOUR_W    = 5,
    parameter int HOUR_MAX  = 24,
    parameter int LAP_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_mode,
    input  logic                          i_run_stop,
    input  logic                          i_clear,
    input  logic                          i_load,
    input  logic [5:0]                    i_set_sec,
    input  logic [5:0]                    i_set_min,
    input  logic [HOUR_W-1:0]             i_set_hour,
    input  logic                          i_lap,
    input  logic                          i_lap_rd,
    output logic [6:0]                    msec,
    output logic [5:0]                    sec,
    output logic [5:0]                    min,
    output logic [HOUR_W-1:0]             hour,
    output logic                          o_running,
    output logic                          o_done,
    output logic [6:0]                    o_lap_msec,
    output logic [5:0]                    o_lap_sec,
    output logic [5:0]                    o_lap_min,
    output logic [HOUR_W-1:0]             o_lap_hour,
    output logic [$clog2(LAP_DEPTH):0]    o_lap_cnt,
    output logic                          o_lap_ovf
);

    localparam int DIV_W  = $clog2(TICK_DIV);
    localparam int PTR_W  = $clog2(LAP_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int SNAP_W = 7 + 6 + 6 + HOUR_W;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOUR_MAX - 1);
    localparam logic [HOUR_W-1:0] HOUR_ONE  = HOUR_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(LAP_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [5:0] sat_59(input logic [5:0] v);
        return (v > 6'd59) ? 6'd59 : v;
    endfunction

    function automatic logic [HOUR_W-1:0] sat_hour(input logic [HOUR_W-1:0] v);
        return (v > HOUR_LAST) ? HOUR_LAST : v;
    endfunction

    state_t              state, state_n;
    logic                mode_q;
    logic [DIV_W-1:0]    div_q;
    logic                done_q;

    logic                time_zero, time_one;
    logic                load_ok, rs_ok, run_adv, tick, down_hit;
    logic [6:0]          msec_n;
    logic [5:0]          sec_n, min_n;
    logic [HOUR_W-1:0]   hour_n;

    logic [SNAP_W-1:0]   lap_mem [LAP_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    lap_cnt;
    logic                lap_ovf;
    logic                lap_push, pop, push_ok, ovf_set;
    logic [SNAP_W-1:0]   snap, head;

    // Control decode: clear > load > run_stop > tick/lap
    assign time_zero = (msec == 7'd0) && (sec == 6'd0) && (min == 6'd0) && (hour == '0);
    assign time_one  = (msec == 7'd1) && (sec == 6'd0) && (min == 6'd0) && (hour == '0);

    assign load_ok = i_load && !i_clear && (state != S_RUN);
    assign rs_ok   = i_run_stop && !i_clear && !load_ok &&
                     ((state == S_RUN) || (state == S_PAUSE) ||
                      ((state == S_IDLE) && !(i_mode && time_zero)));
    assign run_adv  = (state == S_RUN) && !i_clear && !rs_ok;
    assign tick     = run_adv && (div_q == DIV_LAST);
    assign down_hit = tick && mode_q && (time_one || time_zero);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (i_clear || load_ok) begin
            state_n = S_IDLE;
        end else if (rs_ok) begin
            case (state)
                S_IDLE:  state_n = S_RUN;
                S_RUN:   state_n = S_PAUSE;
                S_PAUSE: state_n = S_RUN;
                default: state_n = state;
            endcase
        end else if (down_hit) begin
            state_n = S_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if (state == S_IDLE) begin
                mode_q <= i_mode;
            end
            done_q <= down_hit;
        end
    end

    // Carry chain for count-up, borrow chain for count-down; holds at zero when counting down
    always_comb begin
        msec_n = msec;
        sec_n  = sec;
        min_n  = min;
        hour_n = hour;
        if (tick && !mode_q) begin
            if (msec == 7'd99) begin
                msec_n = 7'd0;
                if (sec == 6'd59) begin
                    sec_n = 6'd0;
                    if (min == 6'd59) begin
                        min_n  = 6'd0;
                        hour_n = (hour == HOUR_LAST) ? '0 : hour + HOUR_ONE;
                    end else begin
                        min_n = min + 6'd1;
                    end
                end else begin
                    sec_n = sec + 6'd1;
                end
            end else begin
                msec_n = msec + 7'd1;
            end
        end else if (tick && mode_q && !time_zero) begin
            if (msec == 7'd0) begin
                msec_n = 7'd99;
                if (sec == 6'd0) begin
                    sec_n = 6'd59;
                    if (min == 6'd0) begin
                        min_n  = 6'd59;
                        hour_n = hour - HOUR_ONE;
                    end else begin
                        min_n = min - 6'd1;
                    end
                end else begin
                    sec_n = sec - 6'd1;
                end
            end else begin
                msec_n = msec - 7'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            msec  <= '0;
            sec   <= '0;
            min   <= '0;
            hour  <= '0;
            div_q <= '0;
        end else if (load_ok) begin
            msec  <= '0;
            sec   <= sat_59(i_set_sec);
            min   <= sat_59(i_set_min);
            hour  <= sat_hour(i_set_hour);
            div_q <= '0;
        end else if (run_adv) begin
            div_q <= tick ? '0 : div_q + DIV_ONE;
            msec  <= msec_n;
            sec   <= sec_n;
            min   <= min_n;
            hour  <= hour_n;
        end
    end

    // Lap FIFO: snapshot is the pre-tick time; a pop in the same cycle frees room for a push
    assign snap     = {msec, sec, min, hour};
    assign lap_push = run_adv && i_lap;
    assign pop      = i_lap_rd && !i_clear && (lap_cnt != '0);
    assign push_ok  = lap_push && ((lap_cnt != CNT_FULL) || pop);
    assign ovf_set  = lap_push && !push_ok;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            lap_cnt <= '0;
            lap_ovf <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push_ok && !pop) begin
                lap_cnt <= lap_cnt + CNT_ONE;
            end else if (!push_ok && pop) begin
                lap_cnt <= lap_cnt - CNT_ONE;
            end
            if (ovf_set) begin
                lap_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            lap_mem[wr_ptr] <= snap;
        end
    end

    assign head = (lap_cnt == '0) ? '0 : lap_mem[rd_ptr];

    assign o_lap_msec = head[SNAP_W-1 -: 7];
    assign o_lap_sec  = head[SNAP_W-8 -: 6];
    assign o_lap_min  = head[SNAP_W-14 -: 6];
    assign o_lap_hour = head[HOUR_W-1:0];
    assign o_lap_cnt  = lap_cnt;
    assign o_lap_ovf  = lap_ovf;
    assign o_running  = (state == S_RUN);
    assign o_done     = done_q;

endmodule

// File: tb/tb_lap_timer_core.sv
// Bench for lap_timer_core: directed scenarios plus random pulses, checked against a
// reference model that tracks time as total centiseconds and the lap FIFO as a queue.
module tb_lap_timer_core;

    localparam int TICK_DIV  = 2;
    localparam int HOUR_W    = 5;
    localparam int HOUR_MAX  = 24;
    localparam int LAP_DEPTH = 2;
    localparam int PERIOD    = HOUR_MAX * 360000;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              i_mode = 1'b0, i_run_stop = 1'b0, i_clear = 1'b0, i_load = 1'b0;
    logic [5:0]        i_set_sec = '0, i_set_min = '0;
    logic [HOUR_W-1:0] i_set_hour = '0;
    logic              i_lap = 1'b0, i_lap_rd = 1'b0;
    logic [6:0]        msec, o_lap_msec;
    logic [5:0]        sec, min, o_lap_sec, o_lap_min;
    logic [HOUR_W-1:0] hour, o_lap_hour;
    logic              o_running, o_done, o_lap_ovf;
    logic [1:0]        o_lap_cnt;

    int checks = 0;
    int failures = 0;

    int m_state = M_IDLE;
    bit m_mode = 1'b0;
    int m_div = 0;
    int m_t = 0;
    int m_q[$];
    bit m_ovf = 1'b0;
    bit m_done = 1'b0;

    lap_timer_core #(
        .TICK_DIV(TICK_DIV), .HOUR_W(HOUR_W), .HOUR_MAX(HOUR_MAX), .LAP_DEPTH(LAP_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .i_mode(i_mode), .i_run_stop(i_run_stop),
        .i_clear(i_clear), .i_load(i_load), .i_set_sec(i_set_sec), .i_set_min(i_set_min),
        .i_set_hour(i_set_hour), .i_lap(i_lap), .i_lap_rd(i_lap_rd),
        .msec(msec), .sec(sec), .min(min), .hour(hour),
        .o_running(o_running), .o_done(o_done),
        .o_lap_msec(o_lap_msec), .o_lap_sec(o_lap_sec), .o_lap_min(o_lap_min),
        .o_lap_hour(o_lap_hour), .o_lap_cnt(o_lap_cnt), .o_lap_ovf(o_lap_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] split(input int t);
        return {7'(t % 100), 6'((t / 100) % 60), 6'((t / 6000) % 60), 5'(t / 360000)};
    endfunction

    function automatic logic [52:0] dut_vec();
        return {msec, sec, min, hour, o_running, o_done,
                o_lap_msec, o_lap_sec, o_lap_min, o_lap_hour, o_lap_cnt, o_lap_ovf};
    endfunction

    function automatic logic [52:0] exp_vec();
        int h;
        h = (m_q.size() > 0) ? m_q[0] : 0;
        return {split(m_t), (m_state == M_RUN), m_done, split(h), 2'(m_q.size()), m_ovf};
    endfunction

    function automatic int clamp(input int v, input int hi);
        return (v > hi) ? hi : v;
    endfunction

    // Behaviour in terms of the documented rules, one clock edge at a time
    function automatic void model_update(input bit r, rs, clr, ld, lp, rd);
        bit was_idle;
        bit push_req;
        int snapv;
        was_idle = (m_state == M_IDLE);
        push_req = 1'b0;
        snapv = m_t;
        if (r) begin
            m_state = M_IDLE; m_mode = 1'b0; m_div = 0; m_t = 0;
            m_q.delete(); m_ovf = 1'b0; m_done = 1'b0;
            return;
        end
        m_done = 1'b0;
        if (clr) begin
            m_state = M_IDLE; m_t = 0; m_div = 0; m_q.delete(); m_ovf = 1'b0;
        end else begin
            if (ld && m_state != M_RUN) begin
                m_t = clamp(int'(i_set_sec), 59) * 100 + clamp(int'(i_set_min), 59) * 6000
                    + clamp(int'(i_set_hour), HOUR_MAX - 1) * 360000;
                m_div = 0;
                m_state = M_IDLE;
            end else if (rs && m_state != M_DONE && !(m_state == M_IDLE && i_mode && m_t == 0)) begin
                if (m_state == M_RUN) m_state = M_PAUSE;
                else m_state = M_RUN;
            end else if (m_state == M_RUN) begin
                push_req = lp;
                if (m_div == TICK_DIV - 1) begin
                    m_div = 0;
                    if (!m_mode) begin
                        m_t = (m_t + 1) % PERIOD;
                    end else if (m_t > 0) begin
                        m_t = m_t - 1;
                        if (m_t == 0) begin
                            m_state = M_DONE;
                            m_done = 1'b1;
                        end
                    end
                end else begin
                    m_div = m_div + 1;
                end
            end
            if (rd && m_q.size() > 0) void'(m_q.pop_front());
            if (push_req) begin
                if (m_q.size() < LAP_DEPTH) m_q.push_back(snapv);
                else m_ovf = 1'b1;
            end
        end
        if (was_idle) m_mode = i_mode;
    endfunction

    task automatic step(input bit r, rs, clr, ld, lp, rd);
        reset = r; i_run_stop = rs; i_clear = clr; i_load = ld; i_lap = lp; i_lap_rd = rd;
        @(posedge clk);
        model_update(r, rs, clr, ld, lp, rd);
        #1;
        reset = 1'b0; i_run_stop = 1'b0; i_clear = 1'b0; i_load = 1'b0;
        i_lap = 1'b0; i_lap_rd = 1'b0;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0);
        checks++;
        if (dut_vec() !== 53'd0) begin
            failures++; $display("FAIL reset_init got=%h exp=0", dut_vec());
        end
        i_mode = 1'b0;
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 1000 && m_t != 307; i++) begin
            step(0, 0, 0, 0, (i % 97) == 5, 0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++; $display("FAIL reset_run cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if ({sec, msec} !== {6'd3, 7'd7} || o_running !== 1'b1) begin
            failures++; $display("FAIL reset_pre got=%0d.%0d run=%b exp=3.7 run=1", sec, msec, o_running);
        end
        step(1, 0, 0, 0, 1, 0);
        checks++;
        if (dut_vec() !== 53'd0) begin
            failures++; $display("FAIL reset_midrun got=%h exp=0", dut_vec());
        end
    endtask

    task automatic test_count_up();
        step(0, 0, 1, 0, 0, 0);
        i_mode = 1'b0;
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 200; i++) begin
            step(0, 0, 0, 0, 0, 0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++; $display("FAIL up_run cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (msec !== 7'd0 || sec !== 6'd1) begin
            failures++; $display("FAIL up_sec_carry got=%0d.%0d exp=1.0", sec, msec);
        end
        step(0, 0, 1, 0, 0, 0);
        i_set_hour = 5'd23; i_set_min = 6'd59; i_set_sec = 6'd59;
        step(0, 0, 0, 1, 0, 0);
        checks++;
        if ({hour, min, sec, msec} !== {5'd23, 6'd59, 6'd59, 7'd0}) begin
            failures++; $display("FAIL up_load got=%0d:%0d:%0d.%0d exp=23:59:59.0", hour, min, sec, msec);
        end
        step(0, 1, 0, 0, 0, 0);
        repeat (198) step(0, 0, 0, 0, 0, 0);
        checks++;
        if (msec !== 7'd99 || hour !== 5'd23) begin
            failures++; $display("FAIL up_pre_wrap got=%0d.%0d exp=23h .99", hour, msec);
        end
        repeat (2) step(0, 0, 0, 0, 0, 0);
        checks++;
        if ({hour, min, sec, msec} !== 24'd0 || o_running !== 1'b1) begin
            failures++; $display("FAIL up_wrap got=%0d:%0d:%0d.%0d run=%b exp=0:0:0.0 run=1",
                                 hour, min, sec, msec, o_running);
        end
    endtask

    task automatic test_count_down();
        int done_at;
        int done_cnt;
        done_at = -1;
        done_cnt = 0;
        step(0, 0, 1, 0, 0, 0);
        i_mode = 1'b1;
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        checks++;
        if (o_running !== 1'b0) begin
            failures++; $display("FAIL down_zero_start got=%b exp=0", o_running);
        end
        i_set_hour = 5'd31; i_set_min = 6'd60; i_set_sec = 6'd63;
        step(0, 0, 0, 1, 0, 0);
        checks++;
        if ({hour, min, sec, msec} !== {5'd23, 6'd59, 6'd59, 7'd0}) begin
            failures++; $display("FAIL load_sat got=%0d:%0d:%0d.%0d exp=23:59:59.0", hour, min, sec, msec);
        end
        i_set_hour = 5'd0; i_set_min = 6'd0; i_set_sec = 6'd1;
        step(0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            step(0, 0, 0, 0, 0, 0);
            if (o_done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++; $display("FAIL down_run cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (done_at != 199 || done_cnt != 1) begin
            failures++; $display("FAIL down_done at=%0d pulses=%0d exp at=199 pulses=1", done_at, done_cnt);
        end
        step(0, 1, 0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0, 0, 0);
        checks++;
        if (o_running !== 1'b0 || {hour, min, sec, msec} !== 24'd0 || o_done !== 1'b0) begin
            failures++; $display("FAIL down_done_rs got run=%b t=%h done=%b exp run=0 t=0 done=0",
                                 o_running, {hour, min, sec, msec}, o_done);
        end
    endtask

    task automatic test_pause();
        step(0, 0, 1, 0, 0, 0);
        i_mode = 1'b0;
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        repeat (7) step(0, 0, 0, 0, 0, 0);
        checks++;
        if (msec !== 7'd3) begin
            failures++; $display("FAIL pause_pre got=%0d exp=3", msec);
        end
        step(0, 1, 0, 0, 0, 0);
        repeat (50) step(0, 0, 0, 0, 0, 0);
        checks++;
        if (msec !== 7'd3 || o_running !== 1'b0) begin
            failures++; $display("FAIL pause_hold got=%0d run=%b exp=3 run=0", msec, o_running);
        end
        step(0, 1, 0, 0, 0, 0);
        checks++;
        if (msec !== 7'd3 || o_running !== 1'b1) begin
            failures++; $display("FAIL pause_resume got=%0d run=%b exp=3 run=1", msec, o_running);
        end
        step(0, 0, 0, 0, 0, 0);
        checks++;
        if (msec !== 7'd4) begin
            failures++; $display("FAIL pause_phase got=%0d exp=4", msec);
        end
    endtask

    task automatic test_laps();
        int s1, s2;
        step(0, 0, 1, 0, 0, 0);
        i_mode = 1'b0;
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        repeat (5) step(0, 0, 0, 0, 0, 0);
        s1 = m_t;
        step(0, 0, 0, 0, 1, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0);
        s2 = m_t;
        step(0, 0, 0, 0, 1, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        checks++;
        if (o_lap_cnt !== 2'd2 || o_lap_ovf !== 1'b1 ||
            {o_lap_msec, o_lap_sec, o_lap_min, o_lap_hour} !== split(s1)) begin
            failures++; $display("FAIL lap_full cnt=%0d ovf=%b head=%0d exp cnt=2 ovf=1 head=%0d",
                                 o_lap_cnt, o_lap_ovf, o_lap_msec, s1 % 100);
        end
        step(0, 0, 0, 0, 1, 1);
        checks++;
        if (o_lap_cnt !== 2'd2 || {o_lap_msec, o_lap_sec, o_lap_min, o_lap_hour} !== split(s2)) begin
            failures++; $display("FAIL lap_full_rdwr cnt=%0d head=%0d exp cnt=2 head=%0d",
                                 o_lap_cnt, o_lap_msec, s2 % 100);
        end
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        checks++;
        if (o_lap_cnt !== 2'd0 || {o_lap_msec, o_lap_sec, o_lap_min, o_lap_hour} !== 24'd0) begin
            failures++; $display("FAIL lap_empty cnt=%0d head=%0d exp cnt=0 head=0", o_lap_cnt, o_lap_msec);
        end
        step(0, 0, 0, 0, 1, 1);
        checks++;
        if (o_lap_cnt !== 2'd1 || o_lap_ovf !== 1'b1 || dut_vec() !== exp_vec()) begin
            failures++; $display("FAIL lap_empty_rdwr got=%h exp=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_clear_combo();
        step(0, 1, 1, 0, 1, 1);
        checks++;
        if (dut_vec() !== 53'd0) begin
            failures++; $display("FAIL clear_combo got=%h exp=0", dut_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) i_mode = 1'($urandom_range(0, 1));
            i_set_sec  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 2));
            i_set_min  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
            i_set_hour = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'd0;
            step($urandom_range(0, 599) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0,
                 $urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++; $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_pause();
        test_laps();
        test_clear_combo();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
